// File: rtl/eeprom_boot_loader.sv
// -----------------------------------------------------------------------------
// eeprom_boot_loader
//
// Boot-image loader sitting directly upstream of the cva6 core. It takes the
// byte stream coming out of the I2C EEPROM reader and parses the image:
//   4-byte little-endian length N (in 32-bit words),
//   4*N payload bytes (little-endian per word),
//   1 checksum byte C, where sum(payload bytes) + C == 0 (mod 256).
// Each packed payload word is written into the core's boot RAM. Once the
// image checksum is verified, the core is released by core_fetch_en_o.
//
// Ports
//   clk_i            clock
//   rst_i            asynchronous, active-high reset
//   start_i          pulse: begin a load (honoured only in IDLE/ERROR)
//   byte_valid_i     EEPROM byte stream valid
//   byte_data_i      EEPROM byte
//   byte_ready_o     loader accepts a byte this cycle
//   mem_we_o         boot RAM write request, held until mem_gnt_i
//   mem_addr_o       boot RAM word address (BASE_ADDR + words written)
//   mem_wdata_o      boot RAM write data
//   mem_gnt_i        boot RAM accepted the write this cycle
//   words_loaded_o   number of words written during the current load
//   core_fetch_en_o  core may fetch; sticky until reset
//   done_o           image loaded and verified; sticky until reset
//   error_o          bad length or bad checksum; sticky until next start/reset
// -----------------------------------------------------------------------------
module eeprom_boot_loader #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    MAX_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH:0]   words_loaded_o,
  output logic                  core_fetch_en_o,
  output logic                  done_o,
  output logic                  error_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            byte_cnt_q;
  logic [31:0]           len_q;
  logic [31:0]           wdata_q;
  logic [ADDR_WIDTH:0]   word_cnt_q;
  logic [7:0]            sum_q;

  logic                  byte_fire;
  logic                  start_ok;
  logic                  last_byte;
  logic [31:0]           len_full;
  logic [ADDR_WIDTH:0]   word_cnt_inc;
  logic [7:0]            sum_final;

  assign byte_fire    = byte_valid_i && byte_ready_o;
  assign start_ok     = start_i && (state_q == S_IDLE || state_q == S_ERROR);
  assign last_byte    = (byte_cnt_q == 2'd3);
  // Length as it will be once the current (4th) header byte lands in [31:24].
  assign len_full     = {byte_data_i, len_q[23:0]};
  assign word_cnt_inc = word_cnt_q + 1'b1;
  assign sum_final    = sum_q + byte_data_i;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d is defaulted first so no path through the case leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_ok) state_d = S_HDR;
      S_HDR: begin
        if (byte_fire && last_byte) begin
          if (len_full == 32'd0 || len_full > 32'(MAX_WORDS)) state_d = S_ERROR;
          else                                               state_d = S_DATA;
        end
      end
      S_DATA:  if (byte_fire && last_byte) state_d = S_WRITE;
      S_WRITE: begin
        if (mem_gnt_i) begin
          if (32'(word_cnt_inc) == len_q) state_d = S_CSUM;
          else                            state_d = S_DATA;
        end
      end
      S_CSUM: begin
        if (byte_fire) state_d = (sum_final == 8'h00) ? S_DONE : S_ERROR;
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: if (start_ok) state_d = S_HDR;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: pure decodes of registered state/datapath, so they change only
  // on a clock edge or on the asynchronous reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    byte_ready_o    = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;
    mem_wdata_o     = '0;
    done_o          = 1'b0;
    core_fetch_en_o = 1'b0;
    error_o         = 1'b0;
    unique case (state_q)
      S_HDR, S_DATA, S_CSUM: byte_ready_o = 1'b1;
      S_WRITE: begin
        mem_we_o    = 1'b1;
        // Address wraps naturally at ADDR_WIDTH bits.
        mem_addr_o  = BASE_ADDR + word_cnt_q[ADDR_WIDTH-1:0];
        mem_wdata_o = wdata_q;
      end
      S_DONE: begin
        done_o          = 1'b1;
        core_fetch_en_o = 1'b1;
      end
      S_ERROR: error_o = 1'b1;
      default: ;
    endcase
  end

  assign words_loaded_o = word_cnt_q;

  // ---------------------------------------------------------------------------
  // Datapath: byte counter, length/word pack registers, word counter, sum.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_cnt_q <= '0;
      len_q      <= '0;
      wdata_q    <= '0;
      word_cnt_q <= '0;
      sum_q      <= '0;
    end else if (start_ok) begin
      // Fresh load or retry: earlier RAM contents are left alone, but all
      // bookkeeping restarts from zero.
      byte_cnt_q <= '0;
      len_q      <= '0;
      wdata_q    <= '0;
      word_cnt_q <= '0;
      sum_q      <= '0;
    end else begin
      if (byte_fire && state_q == S_HDR) begin
        len_q[{byte_cnt_q, 3'b000} +: 8] <= byte_data_i;
        byte_cnt_q                       <= byte_cnt_q + 2'd1;
      end
      if (byte_fire && state_q == S_DATA) begin
        wdata_q[{byte_cnt_q, 3'b000} +: 8] <= byte_data_i;
        sum_q                              <= sum_q + byte_data_i;
        byte_cnt_q                         <= byte_cnt_q + 2'd1;
      end
      if (state_q == S_WRITE && mem_gnt_i) begin
        word_cnt_q <= word_cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_eeprom_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_eeprom_boot_loader
//
// Directed bench for eeprom_boot_loader. A table of image records (bytes,
// stream/grant behaviour, expected result and RAM writes) is applied in a
// loop, followed by hand-written sequences for reset-mid-load and start being
// ignored in DONE. A grant responder logs every accepted write and checks
// that a pending write is held stable while the grant is withheld.
// -----------------------------------------------------------------------------
module tb_eeprom_boot_loader;

  localparam int AW = 12;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          byte_valid_i;
  logic [7:0]    byte_data_i;
  logic          byte_ready_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          mem_gnt_i;
  logic [AW:0]   words_loaded_o;
  logic          core_fetch_en_o;
  logic          done_o;
  logic          error_o;

  eeprom_boot_loader #(
    .ADDR_WIDTH (AW),
    .MAX_WORDS  (1024),
    .BASE_ADDR  ('0)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .byte_valid_i    (byte_valid_i),
    .byte_data_i     (byte_data_i),
    .byte_ready_o    (byte_ready_o),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_gnt_i       (mem_gnt_i),
    .words_loaded_o  (words_loaded_o),
    .core_fetch_en_o (core_fetch_en_o),
    .done_o          (done_o),
    .error_o         (error_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Grant responder and write log (runs on the falling edge).
  // ---------------------------------------------------------------------------
  int            gnt_dly  = 0;
  bit            stab_en  = 1'b0;
  bit            we_seen  = 1'b0;
  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];

  initial begin
    int            wait_cnt;
    logic [AW-1:0] prev_addr;
    logic [31:0]   prev_data;
    wait_cnt  = 0;
    prev_addr = '0;
    prev_data = '0;
    mem_gnt_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (mem_we_o) begin
        if (stab_en && wait_cnt > 0) begin
          check("stall_addr_stable", 32'(mem_addr_o), 32'(prev_addr));
          check("stall_data_stable", mem_wdata_o, prev_data);
          check("stall_ready_low", 32'(byte_ready_o), 32'd0);
        end
        prev_addr = mem_addr_o;
        prev_data = mem_wdata_o;
        we_seen   = 1'b1;
        if (wait_cnt >= gnt_dly) begin
          mem_gnt_i = 1'b1;
          wr_addr.push_back(mem_addr_o);
          wr_data.push_back(mem_wdata_o);
        end else begin
          mem_gnt_i = 1'b0;
        end
        wait_cnt++;
      end else begin
        mem_gnt_i = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0]  b [16];
    int          n;
    bit          gaps;
    int          gnt_dly;
    bit          rst_first;
    bit          exp_done;
    bit          exp_err;
    int          exp_nw;
    logic [31:0] exp_w [2];
  } vec_t;

  vec_t vecs [8];

  // Byte source: presents each byte at a falling edge and holds it until the
  // loader is ready; the following rising edge transfers it.
  task automatic send_bytes(input logic [7:0] b [16], input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        byte_valid_i = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge clk_i);
      end
      byte_valid_i = 1'b1;
      byte_data_i  = b[i];
      begin
        int t;
        t = 0;
        while (!byte_ready_o && t < 200) begin
          @(negedge clk_i);
          t++;
        end
        if (t >= 200) check($sformatf("byte%0d_accept_timeout", i), 32'(byte_ready_o), 32'd1);
      end
      @(negedge clk_i);
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i        = 1'b1;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic run_case(input int idx, input vec_t v);
    if (v.rst_first) do_reset();
    wr_addr.delete();
    wr_data.delete();
    we_seen = 1'b0;
    gnt_dly = v.gnt_dly;
    stab_en = (v.gnt_dly > 0);
    pulse_start();
    check($sformatf("v%0d_start_err_clear", idx), 32'(error_o), 32'd0);
    check($sformatf("v%0d_start_ready", idx), 32'(byte_ready_o), 32'd1);
    send_bytes(v.b, v.n, v.gaps);
    check($sformatf("v%0d_done", idx), 32'(done_o), 32'(v.exp_done));
    check($sformatf("v%0d_error", idx), 32'(error_o), 32'(v.exp_err));
    check($sformatf("v%0d_fetch_en", idx), 32'(core_fetch_en_o), 32'(v.exp_done));
    check($sformatf("v%0d_words_loaded", idx), 32'(words_loaded_o), 32'(v.exp_nw));
    check($sformatf("v%0d_write_count", idx), wr_data.size(), 32'(v.exp_nw));
    if (v.exp_nw == 0) check($sformatf("v%0d_no_we", idx), 32'(we_seen), 32'd0);
    for (int k = 0; k < v.exp_nw && k < wr_data.size(); k++) begin
      check($sformatf("v%0d_w%0d_addr", idx, k), 32'(wr_addr[k]), k);
      check($sformatf("v%0d_w%0d_data", idx, k), wr_data[k], v.exp_w[k]);
    end
    stab_en = 1'b0;
    gnt_dly = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Good 2-word image.
    vecs[0].b = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                  8'h05, 8'h06, 8'h07, 8'h08, 8'hDC, 8'h00, 8'h00, 8'h00};
    vecs[0].n = 13; vecs[0].gaps = 0; vecs[0].gnt_dly = 0; vecs[0].rst_first = 1;
    vecs[0].exp_done = 1; vecs[0].exp_err = 0; vecs[0].exp_nw = 2;
    vecs[0].exp_w = '{32'h0403_0201, 32'h0807_0605};
    // Same image, bad checksum.
    vecs[1] = vecs[0];
    vecs[1].b[12] = 8'hDD;
    vecs[1].exp_done = 0; vecs[1].exp_err = 1;
    // Zero length.
    vecs[2].b = '{default: 8'h00};
    vecs[2].n = 4; vecs[2].gaps = 0; vecs[2].gnt_dly = 0; vecs[2].rst_first = 1;
    vecs[2].exp_done = 0; vecs[2].exp_err = 1; vecs[2].exp_nw = 0;
    vecs[2].exp_w = '{32'h0, 32'h0};
    // Length MAX_WORDS+1 = 0x401, started straight from ERROR.
    vecs[3] = vecs[2];
    vecs[3].b[0] = 8'h01; vecs[3].b[1] = 8'h04;
    vecs[3].rst_first = 0;
    // Retry from ERROR with a good image.
    vecs[4] = vecs[0];
    vecs[4].rst_first = 0;
    // Random stream gaps.
    vecs[5] = vecs[0];
    vecs[5].gaps = 1;
    // Grant withheld 5 cycles per write.
    vecs[6] = vecs[0];
    vecs[6].gnt_dly = 5;
    // Single-word image: AA+BB+CC+DD = 0x30E, checksum 0xF2.
    vecs[7].b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                  8'hF2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[7].n = 9; vecs[7].gaps = 0; vecs[7].gnt_dly = 0; vecs[7].rst_first = 1;
    vecs[7].exp_done = 1; vecs[7].exp_err = 0; vecs[7].exp_nw = 1;
    vecs[7].exp_w = '{32'hDDCC_BBAA, 32'h0};

    rst_i        = 1'b1;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    #1;
    check("rst_ready", 32'(byte_ready_o), 32'd0);
    check("rst_we", 32'(mem_we_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_error", 32'(error_o), 32'd0);
    check("rst_fetch_en", 32'(core_fetch_en_o), 32'd0);
    check("rst_words_loaded", 32'(words_loaded_o), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 8; i++) run_case(i, vecs[i]);

    // start_i in DONE is ignored: still done, not accepting bytes.
    pulse_start();
    @(negedge clk_i);
    check("done_start_ignored_done", 32'(done_o), 32'd1);
    check("done_start_ignored_ready", 32'(byte_ready_o), 32'd0);
    check("done_start_ignored_words", 32'(words_loaded_o), 32'd1);

    // Reset after 3 payload bytes: outputs drop at once, no further writes.
    do_reset();
    we_seen = 1'b0;
    wr_data.delete();
    wr_addr.delete();
    pulse_start();
    send_bytes(vecs[0].b, 7, 1'b0);
    rst_i = 1'b1;
    #1;
    check("midrst_ready", 32'(byte_ready_o), 32'd0);
    check("midrst_we", 32'(mem_we_o), 32'd0);
    check("midrst_addr", 32'(mem_addr_o), 32'd0);
    check("midrst_wdata", mem_wdata_o, 32'd0);
    check("midrst_done", 32'(done_o), 32'd0);
    check("midrst_error", 32'(error_o), 32'd0);
    check("midrst_fetch_en", 32'(core_fetch_en_o), 32'd0);
    check("midrst_words_loaded", 32'(words_loaded_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("midrst_no_write", 32'(we_seen), 32'd0);
    check("midrst_idle_ready", 32'(byte_ready_o), 32'd0);
    begin
      vec_t v;
      v = vecs[0];
      v.rst_first = 0;
      run_case(8, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
